// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared opcode and state types for the accumulate unit
package accum_pkg;
    typedef logic [1:0] op_t;

    localparam op_t OP_LOAD  = 2'b00;
    localparam op_t OP_ADD   = 2'b01;
    localparam op_t OP_SUB   = 2'b10;
    localparam op_t OP_CLEAR = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ripple_adder_n.sv
// rtl/ripple_adder_n.sv - WIDTH-bit ripple-carry adder exposing carry into the MSB
module ripple_adder_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout  = carry[WIDTH];
    assign c_msb = carry[WIDTH-1];
endmodule

// File: rtl/accumulate_unit.sv
// rtl/accumulate_unit.sv - accumulator stage with flags, op counter and valid/ready handshake
module accumulate_unit
    import accum_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_operand,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_acc,
    output logic               out_carry,
    output logic               out_ovf,
    output logic               out_ovf_sticky,
    output logic [COUNT_W-1:0] out_count
);
    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic [WIDTH-1:0]   acc_q;
    logic               carry_q;
    logic               ovf_q;
    logic               sticky_q;
    logic [COUNT_W-1:0] count_q;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               add_c_msb;
    logic               add_ovf;

    // SUB is acc + ~operand + 1, so the adder carry-out means "no borrow"
    assign add_cin = (in_op == OP_SUB);
    assign add_b   = add_cin ? ~in_operand : in_operand;
    assign add_ovf = add_c_msb ^ add_cout;

    ripple_adder_n #(.WIDTH(WIDTH)) u_adder (
        .a     (acc_q),
        .b     (add_b),
        .cin   (add_cin),
        .sum   (add_sum),
        .cout  (add_cout),
        .c_msb (add_c_msb)
    );

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
        in_ready  = (state_q == ST_EMPTY) | out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else if (accept) begin
            case (in_op)
                OP_LOAD: begin
                    acc_q   <= in_operand;
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                end
                OP_ADD, OP_SUB: begin
                    acc_q    <= add_sum;
                    carry_q  <= add_cout;
                    ovf_q    <= add_ovf;
                    sticky_q <= sticky_q | add_ovf;
                    count_q  <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                end
                default: begin
                    acc_q    <= '0;
                    carry_q  <= 1'b0;
                    ovf_q    <= 1'b0;
                    sticky_q <= 1'b0;
                    count_q  <= '0;
                end
            endcase
        end
    end

    // The result registers are the accumulator itself, so out_acc tracks acc even when idle
    assign out_acc        = acc_q;
    assign out_carry      = carry_q;
    assign out_ovf        = ovf_q;
    assign out_ovf_sticky = sticky_q;
    assign out_count      = count_q;
endmodule

// File: tb/tb_accumulate_unit.sv
// tb/tb_accumulate_unit.sv - scoreboard bench for accumulate_unit with a reference model
module tb_accumulate_unit;
    localparam int W  = 4;
    localparam int CW = 4;

    typedef struct {
        logic [W-1:0]  acc;
        logic          c;
        logic          v;
        logic          s;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [W-1:0]  in_operand = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_acc;
    logic          out_carry;
    logic          out_ovf;
    logic          out_ovf_sticky;
    logic [CW-1:0] out_count;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    bit            m_full = 0;
    logic [W-1:0]  m_acc = '0;
    logic          m_sticky = 1'b0;
    logic [CW-1:0] m_count = '0;
    logic [W-1:0]  idle_acc = '0;

    accumulate_unit #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_operand     (in_operand),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_acc        (out_acc),
        .out_carry      (out_carry),
        .out_ovf        (out_ovf),
        .out_ovf_sticky (out_ovf_sticky),
        .out_count      (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views
    function automatic exp_t model_apply(input logic [1:0] op, input logic [W-1:0] d);
        exp_t e;
        int ua, ud, sa, sd, r, sr;
        ua = int'(m_acc);
        ud = int'(d);
        sa = int'($signed(m_acc));
        sd = int'($signed(d));
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            2'b00: m_acc = d;
            2'b01: begin
                r  = ua + ud;
                sr = sa + sd;
                e.c = (r >= (1 << W));
                e.v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
                m_acc = W'(r % (1 << W));
            end
            2'b10: begin
                r  = ua - ud + (1 << W);
                sr = sa - sd;
                e.c = (ua >= ud);
                e.v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
                m_acc = W'(r % (1 << W));
            end
            default: m_acc = '0;
        endcase
        if (op == 2'b11) begin
            m_sticky = 1'b0;
            m_count  = '0;
        end else begin
            m_sticky = m_sticky | e.v;
            m_count  = CW'((int'(m_count) + 1) % (1 << CW));
        end
        e.acc = m_acc;
        e.s   = m_sticky;
        e.cnt = m_count;
        return e;
    endfunction

    // Called at posedge+1; drives one cycle and returns at the next posedge+1
    task automatic step(input bit v, input logic [1:0] op, input logic [W-1:0] d, input bit rdy);
        bit exp_ready;
        bit acc_now;
        in_valid   = v;
        in_op      = op;
        in_operand = d;
        out_ready  = rdy;
        exp_ready  = !m_full || rdy;
        acc_now    = v && exp_ready;
        if (acc_now) sb.push_back(model_apply(op, d));
        @(negedge clk);
        chk("in_ready", int'(in_ready), int'(exp_ready));
        @(posedge clk);
        m_full = acc_now ? 1'b1 : (rdy ? 1'b0 : m_full);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("out_acc",        int'(out_acc),        int'(sb[0].acc));
                    chk("out_carry",      int'(out_carry),      int'(sb[0].c));
                    chk("out_ovf",        int'(out_ovf),        int'(sb[0].v));
                    chk("out_ovf_sticky", int'(out_ovf_sticky), int'(sb[0].s));
                    chk("out_count",      int'(out_count),      int'(sb[0].cnt));
                    if (out_ready) begin
                        idle_acc = sb[0].acc;
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("idle_acc", int'(out_acc), int'(idle_acc));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_acc",   int'(out_acc),   0);
        chk("rst_flags", int'({out_carry, out_ovf, out_ovf_sticky}), 0);
        chk("rst_count", int'(out_count), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(1, 2'b00, 4'b1000, 1);
        step(1, 2'b01, 4'b1111, 1);
        step(1, 2'b00, 4'd3, 1);
        step(1, 2'b10, 4'd5, 1);
        step(1, 2'b00, 4'd7, 1);
        step(1, 2'b10, 4'b1111, 1);
        step(0, 2'b00, 4'd0, 1);

        step(1, 2'b01, 4'd2, 1);
        repeat (3) step(1, 2'b01, 4'd9, 0);
        step(1, 2'b01, 4'd9, 1);
        step(0, 2'b00, 4'd0, 1);

        step(1, 2'b00, 4'd0, 1);
        repeat (5) step(1, 2'b01, 4'd1, 1);
        step(0, 2'b00, 4'd0, 1);

        step(1, 2'b00, 4'd7, 1);
        step(1, 2'b01, 4'd1, 1);
        step(1, 2'b11, 4'd5, 1);
        repeat (17) step(1, 2'b01, 4'd0, 1);
        step(0, 2'b00, 4'd0, 1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 W'($urandom_range(0, (1 << W) - 1)), $urandom_range(0, 3) != 0);
        end
        step(0, 2'b00, 4'd0, 1);

        step(1, 2'b00, 4'd7, 1);
        step(1, 2'b01, 4'd1, 1);
        step(0, 2'b00, 4'd0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  int'(out_valid),      0);
        chk("arst_acc",    int'(out_acc),        0);
        chk("arst_carry",  int'(out_carry),      0);
        chk("arst_ovf",    int'(out_ovf),        0);
        chk("arst_sticky", int'(out_ovf_sticky), 0);
        chk("arst_count",  int'(out_count),      0);
        sb.delete();
        m_full   = 0;
        m_acc    = '0;
        m_sticky = 1'b0;
        m_count  = '0;
        idle_acc = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        step(1, 2'b01, 4'd3, 1);
        repeat (3) step(0, 2'b00, 4'd0, 1);
        chk("drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/accumulate_unit.md
Name: accumulate_unit

Overview:
- Sequential stage directly downstream of the ripple-carry adder.
- Accepts a stream of operands with opcodes and drives the adder from its own accumulator register.
- Registers the adder's sum and carry-out.
- Presents each updated accumulator value with carry and overflow flags on a valid/ready output.

Parameters:
WIDTH, 4, operand/accumulator width in bits (>=2)
COUNT_W, 4, width of accepted-operation counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  unit can accept operand this cycle
in_op  input  2  opcode (see Behaviour)
in_operand  input  WIDTH  operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_acc  output  WIDTH  accumulator value after the operation
out_carry  output  1  adder carry-out of the operation
out_ovf  output  1  signed overflow of the operation
out_ovf_sticky  output  1  OR of all out_ovf since last CLEAR or reset
out_count  output  COUNT_W  operations accepted since last CLEAR or reset, wraps

Behaviour:
- Interface (decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - acc = 0, out_acc = 0.
  - out_valid, out_carry, out_ovf, out_ovf_sticky = 0.
  - out_count = 0.
  - State = EMPTY.
- Reset asserted mid-operation discards any pending result immediately, with no handshake completion.
- Opcodes:
  - 00 LOAD: acc <= operand; carry = 0; ovf = 0.
  - 01 ADD: acc <= acc + operand, adder carry-in 0.
  - 10 SUB: acc <= acc + ~operand + 1, adder carry-in 1. carry = 1 means no borrow.
  - 11 CLEAR: acc <= 0; carry = 0; ovf = 0; sticky <= 0; count <= 0. out_count reports 0.
- Arithmetic:
  - Width-exact WIDTH-bit result; carry = adder carry-out.
  - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement overflow. Valid for ADD and SUB only.
  - sticky <= sticky | ovf.
  - count <= count + 1 mod 2^COUNT_W for every accepted op except CLEAR.
- State machine:
  - Two states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - in_ready = (state == EMPTY) | out_ready. This is a pipelined handshake, combinational from out_ready only.
  - Accept occurs when in_valid & in_ready.
  - EMPTY + accept -> FULL. Result registered at that edge, so out_valid is high the next cycle (latency 1).
  - FULL & out_ready & accept -> FULL, with the new result loaded. Back-to-back throughput is 1 op/cycle.
  - FULL & out_ready & !accept -> EMPTY.
  - FULL & !out_ready -> FULL. out_acc, out_carry, out_ovf, out_ovf_sticky and out_count are held stable. in_ready = 0.
- No accept means acc, flags and count are unchanged.
- in_op and in_operand are sampled only on accept. Values present while in_ready = 0 are ignored.
- The operation always uses the accumulator value of the previous accepted op, including when the prior result is still unconsumed at the moment of acceptance.
- Output registers and acc are the same value. out_acc always equals the current acc, even in EMPTY.

Decomposition:
- Shared package `accum_pkg`:
  - Opcode constants OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR.
  - 2-bit op typedef.
- Sub-module `ripple_adder_n`:
  - Parameter WIDTH; a chain of full_adder instances.
  - Ports a, b, cin -> sum, cout, c_msb (carry into MSB) for the overflow calculation.
  - The accumulate_unit muxes b = operand or ~operand and sets cin per opcode.
- Remaining logic (state register, flags, counter, handshake) stays in accumulate_unit.

Test Plan:
1. WIDTH=4. LOAD 4'b1000, then ADD 4'b1111, out_ready=1 -> results 1000/c0/v0, then 0111/c1/v1. Sticky=1, count=2.
2. LOAD 3, SUB 5 -> acc 4'b1110, carry 0, ovf 0. Then LOAD 7, SUB 4'b1111 -> acc 4'b1000, carry 0, ovf 1.
3. Backpressure: out_ready=0 for 3 cycles after an ADD with in_valid held -> in_ready=0, outputs stable, no second accept. Raising out_ready -> next op accepted in the same cycle, out_valid stays 1.
4. Back-to-back: 5 ADD 1 ops on consecutive cycles from LOAD 0, out_ready=1 -> one result per cycle with acc 1,2,3,4,5. count = 6 (LOAD + 5 ADDs).
5. CLEAR after an overflow -> acc 0, sticky 0, count 0. Then 17 ADD 0 ops -> count wraps to 1 (COUNT_W=4).
6. Assert rst_n low asynchronously while FULL and out_ready=0 -> out_valid, out_acc, flags and count go to 0 without waiting for a clock edge. After release, in_ready=1.
